// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one outstanding data-bus access, misaligned
// halfword/word accesses split into two aligned beats, load alignment and extension.
module lsu_ctrl #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int MEMORY_MODE_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [MEMORY_MODE_WIDTH-1:0] mem_mode,
    input  logic                         mem_unsigned,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         stall,
    output logic [DATA_WIDTH-1:0]        load_data,
    output logic                         done,
    output logic                         fault,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [ADDR_WIDTH-1:0]        bus_addr,
    output logic [3:0]                   bus_be,
    output logic [DATA_WIDTH-1:0]        bus_wdata,
    input  logic                         bus_gnt,
    input  logic                         bus_rvalid,
    input  logic [DATA_WIDTH-1:0]        bus_rdata,
    input  logic                         bus_err
);
    localparam logic [MEMORY_MODE_WIDTH-1:0] BYTE_MODE = MEMORY_MODE_WIDTH'(0);
    localparam logic [MEMORY_MODE_WIDTH-1:0] HALF_MODE = MEMORY_MODE_WIDTH'(1);
    localparam logic [MEMORY_MODE_WIDTH-1:0] WORD_MODE = MEMORY_MODE_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t                       state, state_next;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]        wdata_q, lo_buf, hi_buf;
    logic [MEMORY_MODE_WIDTH-1:0] mode_q;
    logic                         uns_q, we_q, err_q;

    logic                         op;
    logic [1:0]                   offset;
    logic                         split;
    logic [3:0]                   base_mask;
    logic [7:0]                   be_vec;
    logic [2*DATA_WIDTH-1:0]      wdata_vec;
    logic [ADDR_WIDTH-1:0]        word_addr;

    // Align the two captured beats to the access offset, then sign/zero-extend.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [2*DATA_WIDTH-1:0]    pair,
        input logic [1:0]                 off,
        input logic [MEMORY_MODE_WIDTH-1:0] mode,
        input logic                       uns
    );
        logic [2*DATA_WIDTH-1:0] aligned;
        logic signed [7:0]       lane_b;
        logic signed [15:0]      lane_h;
        logic [DATA_WIDTH-1:0]   result;
        aligned = pair >> {off, 3'b000};
        lane_b  = signed'(aligned[7:0]);
        lane_h  = signed'(aligned[15:0]);
        if (mode == BYTE_MODE)
            result = uns ? DATA_WIDTH'(aligned[7:0]) : DATA_WIDTH'(lane_b);
        else if (mode == HALF_MODE)
            result = uns ? DATA_WIDTH'(aligned[15:0]) : DATA_WIDTH'(lane_h);
        else
            result = aligned[DATA_WIDTH-1:0];
        return result;
    endfunction

    assign op        = mem_read | mem_write;
    assign offset    = addr_q[1:0];
    assign split     = ((mode_q == WORD_MODE) && (offset != 2'd0)) ||
                       ((mode_q == HALF_MODE) && (offset == 2'd3));
    assign base_mask = (mode_q == BYTE_MODE) ? 4'b0001 :
                       (mode_q == HALF_MODE) ? 4'b0011 : 4'b1111;
    assign be_vec    = {4'b0000, base_mask} << offset;
    assign wdata_vec = {wdata_q, wdata_q} << {offset, 3'b000};
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            lo_buf  <= '0;
            hi_buf  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (op) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    mode_q  <= mem_mode;
                    uns_q   <= mem_unsigned;
                    we_q    <= mem_write & ~mem_read;
                    err_q   <= 1'b0;
                end
                WAIT0: if (bus_rvalid) begin
                    lo_buf <= bus_rdata;
                    err_q  <= bus_err;
                end
                WAIT1: if (bus_rvalid) begin
                    hi_buf <= bus_rdata;
                    err_q  <= bus_err;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = '0;
        bus_wdata  = '0;
        load_data  = '0;
        case (state)
            IDLE: begin
                stall = op;
                if (op) state_next = REQ0;
            end
            REQ0: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr;
                bus_be    = be_vec[3:0];
                bus_wdata = wdata_vec[DATA_WIDTH-1:0];
                if (bus_gnt) state_next = WAIT0;
            end
            WAIT0: begin
                stall = 1'b1;
                // An error on the first beat abandons the second one.
                if (bus_rvalid) state_next = (bus_err || !split) ? DONE : REQ1;
            end
            REQ1: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr + ADDR_WIDTH'(4);
                bus_be    = be_vec[7:4];
                bus_wdata = wdata_vec[2*DATA_WIDTH-1:DATA_WIDTH];
                if (bus_gnt) state_next = WAIT1;
            end
            WAIT1: begin
                stall = 1'b1;
                if (bus_rvalid) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                fault      = err_q;
                state_next = IDLE;
                if (!we_q) load_data = extend_load({hi_buf, lo_buf}, offset, mode_q, uns_q);
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a table of directed accesses, a reset-in-flight sequence,
// and random accesses checked against a byte-lane reference model.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, done, fault, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid, bus_err;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_MODE_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .load_data(load_data), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  mode;
        logic        uns;
        logic [31:0] addr, wdata, rd0, rd1;
        int          gdly;
        int          errb;
        logic [31:0] e_load;
        logic [3:0]  e_be0, e_be1;
        logic [31:0] e_addr0;
        int          e_nb;
        int          e_stalls;
        logic        e_fault;
    } txn_t;

    typedef struct {
        int          nb;
        int          stalls;
        logic [31:0] baddr[2];
        logic [3:0]  bbe[2];
        logic [31:0] bwd[2];
        logic        bwe[2];
        logic        unstable;
        logic        seen;
        logic        stall_at_done;
        logic [31:0] load;
        logic        flt;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic rd, input logic wr, input logic [1:0] mode,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd0, input logic [31:0] rd1, input int gdly,
                                input int errb, input logic [31:0] e_load, input logic [3:0] e_be0,
                                input logic [3:0] e_be1, input logic [31:0] e_addr0, input int e_nb,
                                input int e_stalls, input logic e_fault);
        txn_t t;
        t.rd = rd; t.wr = wr; t.mode = mode; t.uns = uns; t.addr = addr; t.wdata = wdata;
        t.rd0 = rd0; t.rd1 = rd1; t.gdly = gdly; t.errb = errb; t.e_load = e_load;
        t.e_be0 = e_be0; t.e_be1 = e_be1; t.e_addr0 = e_addr0; t.e_nb = e_nb;
        t.e_stalls = e_stalls; t.e_fault = e_fault;
        return t;
    endfunction

    // Reference: view the two bus words as an 8-byte window and pick bytes out of it.
    function automatic txn_t model(input txn_t t);
        txn_t        r;
        int          size, off, nb;
        logic [7:0]  mem[8];
        logic [7:0]  m8;
        logic [31:0] val;
        r    = t;
        size = 1 << t.mode;
        off  = int'(t.addr[1:0]);
        nb   = (off + size > 4) ? 2 : 1;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = t.rd0[8*i +: 8];
            mem[4 + i] = t.rd1[8*i +: 8];
        end
        m8  = 8'h00;
        val = 32'h0;
        for (int i = 0; i < size; i++) begin
            m8[off + i]    = 1'b1;
            val[8*i +: 8]  = mem[off + i];
        end
        if (!t.uns && size < 4 && val[8*size - 1])
            for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
        r.e_load   = t.rd ? val : 32'h0;
        r.e_be0    = m8[3:0];
        r.e_be1    = m8[7:4];
        r.e_addr0  = {t.addr[31:2], 2'b00};
        r.e_nb     = (t.errb == 1) ? 1 : nb;
        r.e_stalls = 1 + r.e_nb * (t.gdly + 2);
        r.e_fault  = (t.errb != 0);
        return r;
    endfunction

    task automatic run_txn(input txn_t t, output obs_t o);
        int   wait_cnt;
        logic resp;
        o.nb = 0; o.stalls = 0; o.unstable = 1'b0; o.seen = 1'b0;
        o.stall_at_done = 1'b0; o.load = 32'h0; o.flt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            o.baddr[b] = 32'h0; o.bbe[b] = 4'h0; o.bwd[b] = 32'h0; o.bwe[b] = 1'b0;
        end
        wait_cnt = 0;
        resp     = 1'b0;
        @(posedge clk); #1;
        mem_read = t.rd; mem_write = t.wr; mem_mode = t.mode; mem_unsigned = t.uns;
        mem_addr = t.addr; mem_wdata = t.wdata;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
            if (done) begin
                o.seen = 1'b1; o.load = load_data; o.flt = fault; o.stall_at_done = stall;
                break;
            end
            if (stall) o.stalls++;
            if (resp) begin
                resp       = 1'b0;
                bus_rvalid = 1'b1;
                bus_rdata  = (o.nb == 1) ? t.rd0 : t.rd1;
                bus_err    = (t.errb == o.nb);
            end else if (bus_req) begin
                if (o.nb >= 2) begin
                    o.nb = 3;
                    break;
                end
                if (wait_cnt == 0) begin
                    o.baddr[o.nb] = bus_addr; o.bbe[o.nb] = bus_be;
                    o.bwd[o.nb] = bus_wdata;  o.bwe[o.nb] = bus_we;
                end else if (bus_addr !== o.baddr[o.nb] || bus_be !== o.bbe[o.nb] ||
                             bus_wdata !== o.bwd[o.nb] || bus_we !== o.bwe[o.nb]) begin
                    o.unstable = 1'b1;
                end
                if (wait_cnt == t.gdly) begin
                    bus_gnt = 1'b1; resp = 1'b1; wait_cnt = 0; o.nb++;
                end else begin
                    wait_cnt++;
                end
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic check_txn(input string tag, input txn_t t, input obs_t o);
        int size, off, lane, beat;
        chk({tag, "_done"}, 32'(o.seen), 32'd1);
        chk({tag, "_stall_cycles"}, o.stalls, t.e_stalls);
        chk({tag, "_stall_in_done"}, 32'(o.stall_at_done), 32'd0);
        chk({tag, "_beats"}, o.nb, t.e_nb);
        chk({tag, "_fault"}, 32'(o.flt), 32'(t.e_fault));
        chk({tag, "_req_stable"}, 32'(o.unstable), 32'd0);
        if (o.nb >= 1) begin
            chk({tag, "_addr0"}, o.baddr[0], t.e_addr0);
            chk({tag, "_be0"}, 32'(o.bbe[0]), 32'(t.e_be0));
            chk({tag, "_we0"}, 32'(o.bwe[0]), 32'(t.wr & ~t.rd));
        end
        if (t.e_nb == 2 && o.nb == 2) begin
            chk({tag, "_addr1"}, o.baddr[1], t.e_addr0 + 32'd4);
            chk({tag, "_be1"}, 32'(o.bbe[1]), 32'(t.e_be1));
            chk({tag, "_we1"}, 32'(o.bwe[1]), 32'(t.wr & ~t.rd));
        end
        if (!t.e_fault) chk({tag, "_load_data"}, o.load, t.e_load);
        if (t.wr && !t.rd) begin
            size = 1 << t.mode;
            off  = int'(t.addr[1:0]);
            for (int i = 0; i < size; i++) begin
                lane = off + i;
                beat = lane / 4;
                if (beat < o.nb && beat < 2)
                    chk({tag, "_wdata_lane"}, 32'(o.bwd[beat][8*(lane % 4) +: 8]),
                        32'(t.wdata[8*i +: 8]));
            end
        end
    endtask

    initial begin
        txn_t tbl[13];
        txn_t t;
        obs_t o;
        int   k;

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_mode = 2'd0; mem_unsigned = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_bus_we", 32'(bus_we), 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_be", 32'(bus_be), 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //            rd    wr    mode  uns   addr          wdata         rd0           rd1           g  e  e_load        be0   be1   addr0         nb st flt
        tbl[0]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 4'hF, 4'h0, 32'h00000100, 1, 3, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        32'h80123456, 32'h0,        0, 0, 32'hFFFFFF80, 4'h8, 4'h0, 32'h00000100, 1, 3, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'h80123456, 32'h0,        0, 0, 32'h00000080, 4'h8, 4'h0, 32'h00000100, 1, 3, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h00000102, 32'hFFFF1234, 32'h0,        32'h0,        0, 0, 32'h00000000, 4'hC, 4'h0, 32'h00000100, 1, 3, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h00000101, 32'hAABBCCDD, 32'h0,        32'h0,        0, 0, 32'h00000000, 4'hE, 4'h1, 32'h00000100, 2, 5, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000106, 32'h0,        32'h11223344, 32'h55667788, 2, 0, 32'h77881122, 4'hC, 4'h3, 32'h00000104, 2, 9, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000106, 32'h0,        32'h11223344, 32'h55667788, 0, 1, 32'h00000000, 4'hC, 4'h3, 32'h00000104, 1, 3, 1'b1);
        tbl[7]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0,        32'hAABBCCDD, 32'h11223344, 0, 0, 32'h3344AABB, 4'hC, 4'h3, 32'hFFFFFFFC, 2, 5, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h00000103, 32'h0,        32'h7F000000, 32'h000000FF, 0, 0, 32'hFFFFFF7F, 4'h8, 4'h1, 32'h00000100, 2, 5, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h00000002, 32'h0,        32'h89AB0000, 32'h0,        0, 0, 32'h000089AB, 4'hC, 4'h0, 32'h00000000, 1, 3, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h00000001, 32'h12345678, 32'h0,        32'h0,        0, 0, 32'h00000000, 4'h2, 4'h0, 32'h00000000, 1, 3, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 2'd2, 1'b0, 32'h00000200, 32'hCAFEF00D, 32'h01020304, 32'h0,        0, 0, 32'h01020304, 4'hF, 4'h0, 32'h00000200, 1, 3, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h00000102, 32'h55667788, 32'h0,        32'h0,        1, 2, 32'h00000000, 4'hC, 4'h3, 32'h00000100, 2, 7, 1'b1);

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i], o);
            check_txn($sformatf("vec%0d", i), tbl[i], o);
        end

        // Reset while waiting for the first response; the late response must be dropped.
        @(posedge clk); #1;
        mem_read = 1'b1; mem_mode = 2'd2; mem_unsigned = 1'b0; mem_addr = 32'h00000300;
        @(negedge clk);
        chk("rstseq_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("rstseq_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rstseq_wait0_stall", 32'(stall), 32'd1);
        chk("rstseq_wait0_req", 32'(bus_req), 32'd0);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstseq_after_stall", 32'(stall), 32'd0);
        chk("rstseq_after_req", 32'(bus_req), 32'd0);
        chk("rstseq_after_done", 32'(done), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678; bus_err = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        chk("rstseq_late_done", 32'(done), 32'd0);
        chk("rstseq_late_fault", 32'(fault), 32'd0);
        chk("rstseq_late_stall", 32'(stall), 32'd0);
        chk("rstseq_late_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("rstseq_late2_done", 32'(done), 32'd0);
        chk("rstseq_late2_load", load_data, 32'd0);

        for (int n = 0; n < 200; n++) begin
            k       = int'($urandom_range(2));
            t.rd    = (k != 1);
            t.wr    = (k != 0);
            t.mode  = 2'($urandom_range(2));
            t.uns   = 1'($urandom_range(1));
            t.addr  = $urandom;
            if ($urandom_range(7) == 0) t.addr = 32'hFFFFFFFC | 32'($urandom_range(3));
            t.wdata = $urandom;
            t.rd0   = $urandom;
            t.rd1   = $urandom;
            t.gdly  = int'($urandom_range(2));
            t.errb  = 0;
            t       = model(t);
            if ($urandom_range(7) == 0) t.errb = int'($urandom_range(t.e_nb, 1));
            t       = model(t);
            run_txn(t, o);
            check_txn($sformatf("rnd%0d", n), t, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
